// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, the halt opcode and the fetch FSM state encoding
// used by fetch_unit and pc_reg.
//   PC_W      - program counter width (8)
//   INST_W    - instruction word width (9)
//   HALT_WORD - opcode that stops fetching (9'b111_111_111)
//   fetch_state_t - IDLE / RUN / HALT
package cpu_pkg;

  localparam int PC_W   = 8;
  localparam int INST_W = 9;

  localparam logic [INST_W-1:0] HALT_WORD = 9'b111_111_111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Sequential next address; 255 rolls over to 0 through natural truncation.
  function automatic logic [PC_W-1:0] pc_plus1(input logic [PC_W-1:0] p);
    return p + PC_W'(1);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: 8-bit program counter with load, increment-with-wrap and hold.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset, clears pc to 0
//   load     - load load_val (has priority over inc)
//   load_val - absolute address to load
//   inc      - advance pc by one, modulo 256
//   pc       - current program counter
// With neither load nor inc asserted the counter holds.
module pc_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p1 <= '0;
    end else if (load) begin
      pc_p1 <= load_val;
    end else if (inc) begin
      pc_p1 <= pc_plus1(pc_p1);
    end
  end

  assign pc = pc_p1;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a three-state controller
// (IDLE, RUN, HALT). Drives pc to a combinational ROM, registers the
// returned word into inst_out one cycle later, squashes the wrong-path
// word on a branch redirect and stops on HALT_WORD.
// Ports:
//   CLK           - clock, rising edge
//   reset         - synchronous active-high reset (beats every other input)
//   start         - begin fetching at pc 0; accepted in IDLE or HALT only
//   stall         - hold pc and the inst_out/inst_valid register
//   branch_taken  - redirect request for the instruction now in inst_out
//   branch_target - absolute redirect address
//   pc            - ROM address
//   inst_in       - ROM word for pc, same cycle
//   inst_out      - registered instruction to decode
//   inst_valid    - inst_out is real and not squashed
//   done          - high while in HALT
//   cycle_count   - (only with FETCH_CYCLE_COUNT_EN) saturating count of
//                   RUN cycles, cleared by reset and by an accepted start,
//                   frozen in HALT
module fetch_unit
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   pc,
  input  logic [INST_W-1:0] inst_in,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid,
  output logic              done
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [15:0]       cycle_count
`endif
);

  fetch_state_t state, state_nxt;

  logic            pc_load;
  logic [PC_W-1:0] pc_load_val;
  logic            pc_inc;

  logic              inst_we;
  logic              vld_nxt;
  logic [INST_W-1:0] inst_p1;
  logic              vld_p1;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Priority inside RUN: redirect, then stall, then halt detection, then
  // normal sequential fetch. A redirect drops the word currently on
  // inst_in because it was fetched down the wrong path.
  always_comb begin
    state_nxt   = state;
    pc_load     = 1'b0;
    pc_load_val = '0;
    pc_inc      = 1'b0;
    inst_we     = 1'b0;
    vld_nxt     = vld_p1;
    case (state)
      IDLE: begin
        vld_nxt = 1'b0;
        if (start) begin
          state_nxt = RUN;
          pc_load   = 1'b1;
        end
      end
      RUN: begin
        if (branch_taken) begin
          pc_load     = 1'b1;
          pc_load_val = branch_target;
          vld_nxt     = 1'b0;
        end else if (stall) begin
          vld_nxt = vld_p1;
        end else if (inst_in == HALT_WORD) begin
          state_nxt = HALT;
          vld_nxt   = 1'b0;
        end else begin
          inst_we = 1'b1;
          vld_nxt = 1'b1;
          pc_inc  = 1'b1;
        end
      end
      HALT: begin
        vld_nxt = 1'b0;
        if (start) begin
          state_nxt = RUN;
          pc_load   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_load   = 1'b1;
        vld_nxt   = 1'b0;
      end
    endcase
  end

  pc_reg u_pc_reg (
    .clk      (CLK),
    .reset    (reset),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  // ---- stage p1: fetched word to decode ----
  always_ff @(posedge CLK) begin
    if (reset) begin
      inst_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (inst_we) begin
        inst_p1 <= inst_in;
      end
      vld_p1 <= vld_nxt;
    end
  end

  assign inst_out   = inst_p1;
  assign inst_valid = vld_p1;
  assign done       = (state == HALT);

`ifdef FETCH_CYCLE_COUNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] cnt_p1;

  // An accepted start (IDLE or HALT) restarts the count; start seen in
  // RUN is ignored like everywhere else.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_p1 <= '0;
    end else if (start && (state != RUN)) begin
      cnt_p1 <= '0;
    end else if (state == RUN) begin
      cnt_p1 <= sat_inc16(cnt_p1);
    end
  end

  assign cycle_count = cnt_p1;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_pkg::*;

  logic              CLK;
  logic              reset;
  logic              start;
  logic              stall;
  logic              branch_taken;
  logic [7:0]        branch_target;
  logic [7:0]        pc;
  logic [8:0]        inst_in;
  logic [8:0]        inst_out;
  logic              inst_valid;
  logic              done;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0]       cycle_count;
`endif

  logic [8:0] rom [256];

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit dut (
    .CLK           (CLK),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .inst_in       (inst_in),
    .inst_out      (inst_out),
    .inst_valid    (inst_valid),
    .done          (done)
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    .cycle_count   (cycle_count)
`endif
  );

  assign inst_in = rom[pc];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       rst;
    logic       st;
    logic       stl;
    logic       br;
    logic [7:0] tgt;
    logic [7:0] e_pc;
    logic [8:0] e_inst;
    logic       e_vld;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic st, input logic stl,
                              input logic br, input logic [7:0] tgt,
                              input logic [7:0] e_pc, input logic [8:0] e_inst,
                              input logic e_vld, input logic e_done);
    vec_t v;
    v.rst = rst; v.st = st; v.stl = stl; v.br = br; v.tgt = tgt;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_vld = e_vld; v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, settle just after it.
  task automatic step(input logic rst, input logic st, input logic stl,
                      input logic br, input logic [7:0] tgt);
    reset = rst; start = st; stall = stl; branch_taken = br; branch_target = tgt;
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] e_pc,
                            input logic [8:0] e_inst, input logic e_vld,
                            input logic e_done);
    chk({tag, " pc"},    16'(pc),         16'(e_pc));
    chk({tag, " inst"},  16'(inst_out),   16'(e_inst));
    chk({tag, " vld"},   16'(inst_valid), 16'(e_vld));
    chk({tag, " done"},  16'(done),       16'(e_done));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'(i);
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'd0;

    //            rst st stl br tgt    pc     inst   vld done
    vecs.push_back(mk(1, 0, 0, 0, 8'd0,   8'd0,   9'd0,  0, 0)); // reset state
    vecs.push_back(mk(0, 1, 0, 0, 8'd0,   8'd0,   9'd0,  0, 0)); // start -> RUN, pc 0
    vecs.push_back(mk(0, 0, 0, 0, 8'd0,   8'd1,   9'd0,  1, 0)); // valid rises
    vecs.push_back(mk(0, 0, 0, 0, 8'd0,   8'd2,   9'd1,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'd0,   8'd3,   9'd2,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'd0,   8'd4,   9'd3,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'd0,   8'd5,   9'd4,  1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'd37,  8'd37,  9'd4,  0, 0)); // branch at pc 5
    vecs.push_back(mk(0, 0, 0, 0, 8'd0,   8'd38,  9'd37, 1, 0)); // word 5 skipped
    vecs.push_back(mk(0, 1, 0, 0, 8'd0,   8'd39,  9'd38, 1, 0)); // start in RUN ignored
    vecs.push_back(mk(0, 0, 0, 1, 8'd9,   8'd9,   9'd38, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'd0,   8'd10,  9'd9,  1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'd0,   8'd10,  9'd9,  1, 0)); // stall x3
    vecs.push_back(mk(0, 0, 1, 0, 8'd0,   8'd10,  9'd9,  1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'd0,   8'd10,  9'd9,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'd0,   8'd11,  9'd10, 1, 0)); // resume
    vecs.push_back(mk(0, 0, 1, 1, 8'd100, 8'd100, 9'd10, 0, 0)); // branch beats stall
    vecs.push_back(mk(0, 0, 1, 0, 8'd0,   8'd100, 9'd10, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 8'd0,   8'd0,   9'd0,  0, 0)); // reset mid-run, stalled
    vecs.push_back(mk(1, 1, 0, 1, 8'd50,  8'd0,   9'd0,  0, 0)); // reset beats start
    vecs.push_back(mk(0, 0, 0, 0, 8'd0,   8'd0,   9'd0,  0, 0)); // still IDLE
    vecs.push_back(mk(0, 0, 1, 1, 8'd50,  8'd0,   9'd0,  0, 0)); // IDLE ignores branch

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].stl, vecs[i].br, vecs[i].tgt);
      expect_out($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_inst,
                 vecs[i].e_vld, vecs[i].e_done);
    end

    // Halt word at 254
    rom[254] = 9'h1FF;
    step(0, 1, 0, 0, 8'd0);   expect_out("h_start", 8'd0,   9'd0,   0, 0);
    step(0, 0, 0, 1, 8'd253); expect_out("h_br",    8'd253, 9'd0,   0, 0);
    step(0, 0, 0, 0, 8'd0);   expect_out("h_253",   8'd254, 9'd253, 1, 0);
    step(0, 0, 0, 0, 8'd0);   expect_out("h_halt",  8'd254, 9'd253, 0, 1);
    step(0, 0, 1, 1, 8'd7);   expect_out("h_ign",   8'd254, 9'd253, 0, 1);
    step(0, 1, 0, 0, 8'd0);   expect_out("h_rest",  8'd0,   9'd253, 0, 0);
    step(0, 0, 0, 0, 8'd0);   expect_out("h_run",   8'd1,   9'd0,   1, 0);

    // Branch taken while halt word is on inst_in: branch wins
    step(0, 0, 0, 1, 8'd254); expect_out("bh_to",   8'd254, 9'd0,   0, 0);
    step(0, 0, 0, 1, 8'd20);  expect_out("bh_br",   8'd20,  9'd0,   0, 0);
    step(0, 0, 0, 0, 8'd0);   expect_out("bh_run",  8'd21,  9'd20,  1, 0);

    // Straight-line wrap 255 -> 0
    rom[254] = 9'd254;
    step(0, 0, 0, 1, 8'd254); expect_out("w_br",    8'd254, 9'd20,  0, 0);
    step(0, 0, 0, 0, 8'd0);   expect_out("w_254",   8'd255, 9'd254, 1, 0);
    step(0, 0, 0, 0, 8'd0);   expect_out("w_255",   8'd0,   9'd255, 1, 0);
    step(0, 0, 0, 0, 8'd0);   expect_out("w_0",     8'd1,   9'd0,   1, 0);

`ifdef FETCH_CYCLE_COUNT_EN
    step(1, 0, 0, 0, 8'd0);   chk("cc_rst",  cycle_count, 16'd0);
    step(0, 1, 0, 0, 8'd0);   chk("cc_st",   cycle_count, 16'd0);
    step(0, 0, 0, 0, 8'd0);
    step(0, 0, 1, 0, 8'd0);
    step(0, 0, 0, 1, 8'd254); chk("cc_run3", cycle_count, 16'd3);
    rom[254] = 9'h1FF;
    step(0, 0, 0, 0, 8'd0);   chk("cc_halt", cycle_count, 16'd4);
    step(0, 0, 0, 0, 8'd0);   chk("cc_frz",  cycle_count, 16'd4);
    rom[254] = 9'd254;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: begin fetching at PC 0; honoured in IDLE or HALT only.
REQ-004 SHALL have port stall, input, 1 bit: hold PC and the inst_out/inst_valid pipeline register.
REQ-005 SHALL have port branch_taken, input, 1 bit: redirect request from execute for the instruction currently in inst_out.
REQ-006 SHALL have port branch_target, input, 8 bits: absolute redirect PC.
REQ-007 SHALL have port pc, output, 8 bits: address driven to the combinational instruction ROM.
REQ-008 SHALL have port inst_in, input, 9 bits: ROM word for pc, valid in the same cycle.
REQ-009 SHALL have port inst_out, output, 9 bits: registered instruction to decode.
REQ-010 SHALL have port inst_valid, output, 1 bit: inst_out is a real, non-squashed instruction.
REQ-011 SHALL have port done, output, 1 bit: high while in HALT.

Function
REQ-012 SHALL implement states IDLE, RUN and HALT.
REQ-013 IDLE: pc = 0 and inst_valid = 0; start moves to RUN the next cycle with pc = 0.
REQ-014 RUN, stall = 0, branch_taken = 0: inst_out <= inst_in; inst_valid <= 1; pc <= pc + 1, modulo 256 (255 wraps to 0).
REQ-015 RUN, branch_taken = 1: pc <= branch_target; inst_valid <= 0, squashing the wrong-path word; this takes priority over stall and over halt detection.
REQ-016 RUN, stall = 1, branch_taken = 0: pc, inst_out and inst_valid hold.
REQ-017 RUN, inst_in = HALT_WORD (9'b111_111_111), no stall, no branch: go to HALT; inst_valid <= 0; pc holds the halt address.
REQ-018 HALT: done = 1; pc holds; inst_valid = 0; stall and branch_taken are ignored.
REQ-019 HALT with start = 1: go to RUN with pc = 0 and done = 0 the next cycle.
REQ-020 start asserted in RUN SHALL be ignored.
REQ-021 Fetch-to-inst_out latency SHALL be exactly 1 cycle when not stalled.

Reset
REQ-022 reset SHALL force, on the next edge and from any state including mid-run: state = IDLE, pc = 0, inst_out = 0, inst_valid = 0, done = 0.
REQ-023 reset SHALL take priority over start, stall and branch_taken.

Configuration
REQ-024 With FETCH_CYCLE_COUNT_EN defined, the block SHALL add output cycle_count (16 bits), which counts RUN cycles, clears on reset and on start, saturates at 16'hFFFF, and freezes in HALT.
REQ-025 Without FETCH_CYCLE_COUNT_EN, the cycle_count port and counter logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-026 Package cpu_pkg SHALL hold PC_W = 8, INST_W = 9, HALT_WORD, and the fetch state enum (IDLE, RUN, HALT).
REQ-027 Sub-module pc_reg (the 8-bit PC with hold, load and increment-with-wrap) SHALL be instantiated once; all other logic stays in fetch_unit.

Verification
REQ-028 Reset then start, ROM of NOPs -> pc sequence 0,1,2,3; inst_valid rises 1 cycle after start's RUN entry.
REQ-029 branch_taken = 1 with branch_target = 8'd37 at pc = 5 -> next pc = 37; inst_valid = 0 for one cycle; the word at 5 is never presented.
REQ-030 stall held 3 cycles at pc = 10 -> pc stays 10; inst_out unchanged; resumes at 11.
REQ-031 ROM word 9'h1FF at pc = 254 -> state HALT; done = 1; pc = 254; inst_valid = 0; a following start -> pc = 0, done = 0.
REQ-032 Straight-line run through pc = 255 -> pc wraps to 0; reset asserted at pc = 100 with stall = 1 -> IDLE, pc = 0 next cycle.
REQ-033 Simultaneous branch_taken and inst_in = 9'h1FF -> branch taken, no HALT; with FETCH_CYCLE_COUNT_EN, cycle_count equals the number of RUN cycles.
